// File: rtl/seg_scan_display_pkg.sv
// Shared constants, converter state type and helpers for the scanned 7-segment display.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {IDLE, CONV} conv_state_e;

  // Smallest digit count d with 10^d > 2^bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_v;
    longint unsigned pow;
    int              d;
    max_v = (64'd1 << bin_w) - 64'd1;
    pow   = 64'd10;
    d     = 1;
    while (pow <= max_v) begin
      pow = pow * 64'd10;
      d++;
    end
    return d;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    case (code)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Valid/ready value bus feeding the scanned display.
interface seg_scan_display_if #(
    parameter int BIN_W = 8
);
    logic [BIN_W-1:0] value_i;
    logic             valid_i;
    logic             ready_o;

    modport master (output value_i, output valid_i, input ready_o);
    modport slave  (input value_i, input valid_i, output ready_o);
endinterface

// File: rtl/seg_scan_display_conv.sv
// Sequential shift-add-3 binary to BCD converter with valid/ready intake.
module bcd_seq_conv
    import seg_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      value,
    input  logic                  valid,
    output logic                  ready,
    output logic                  commit,
    output logic [DIGITS*4-1:0]   result
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e          state, state_nxt;
    logic [BIN_W-1:0]     shreg;
    logic [DIGITS*4-1:0]  acc, adj, acc_nxt;
    logic [CNT_W-1:0]     cnt;

    always_comb begin
        adj = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc[i*4 +: 4] > 4'd4)
                adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
        acc_nxt = {adj[DIGITS*4-2:0], shreg[BIN_W-1]};
    end

    assign result = acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) state_nxt = CONV;
            end
            CONV: begin
                // Last shift lands directly in the display register via commit.
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == IDLE && valid) begin
            shreg <= value;
            acc   <= '0;
            cnt   <= CNT_W'(BIN_W);
        end else if (state == CONV) begin
            shreg <= {shreg[BIN_W-2:0], 1'b0};
            acc   <= acc_nxt;
            cnt   <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Binary value to multiplexed 7-segment display: BCD converter, display register, scanner.
// Optional SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int BIN_W     = 8,
    parameter int DIGITS    = 3,
    parameter int SCAN_DIV  = 1024,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_display_if.slave   bus,
    input  logic                enable_i,
    output logic [6:0]          seg_o,
    output logic [DIGITS-1:0]   dig_n_o
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("seg_scan_display: DIGITS too small for BIN_W");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("seg_scan_display: SCAN_DIV must be at least 2");
    end
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
        $error("seg_scan_display: BLANK_CYC must be below SCAN_DIV");
    end

    logic                      commit;
    logic [DIGITS*4-1:0]       result;
    logic [DIGITS-1:0][3:0]    disp;
    logic [PRESC_W-1:0]        presc;
    logic [IDX_W-1:0]          idx;
    logic                      active;
    logic                      blank;

    bcd_seq_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (bus.value_i),
        .valid  (bus.valid_i),
        .ready  (bus.ready_o),
        .commit (commit),
        .result (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      disp <= '0;
        else if (commit) disp <= result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= IDX_W'(DIGITS - 1);
        end else if (presc == PRESC_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == '0) ? IDX_W'(DIGITS - 1) : idx - IDX_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    assign active = (presc >= PRESC_W'(BLANK_CYC)) && enable_i;

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] lead_zero;

    // lead_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (disp[DIGITS-1] == 4'd0);
        for (int unsigned i = 1; i < DIGITS; i++)
            lead_zero[DIGITS-1-i] = lead_zero[DIGITS-i] && (disp[DIGITS-1-i] == 4'd0);
        blank = (idx != '0) && lead_zero[idx];
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= '0;
            dig_n_o <= '1;
        end else if (active) begin
            seg_o   <= blank ? SEG_BLANK : seg_encode(disp[idx]);
            dig_n_o <= ~(DIGITS'(1) << idx);
        end else begin
            seg_o   <= '0;
            dig_n_o <= '1;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=8, BLANK_CYC=2, BIN_W=8, DIGITS=3.
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_i;
    logic [6:0] seg_o;
    logic [2:0] dig_n_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned edges    = 0;
    logic [11:0] disp_m;
    logic        en_m;

    logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seg_scan_display_if #(.BIN_W(8)) bus ();

    seg_scan_display #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .enable_i (enable_i),
        .seg_o    (seg_o),
        .dig_n_o  (dig_n_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edges, obs, exp);
        end
    endtask

    // Output expected after edge j: slot (j-1)/8 selects digit 2,1,0,...; cycles 0..1 of a slot are dark.
    function automatic void model(input int unsigned j, input logic [11:0] d, input logic en,
                                  output logic [6:0] s, output logic [2:0] dn);
        int unsigned p, idx;
        logic [3:0]  dig;
        p   = (j - 1) % 8;
        idx = 2 - (((j - 1) / 8) % 3);
        s   = 7'b0000000;
        dn  = 3'b111;
        if (p >= 2 && en) begin
            dn[idx] = 1'b0;
            dig     = d[idx*4 +: 4];
            s       = (dig < 10) ? seg_tbl[dig] : 7'b0000000;
`ifdef SEG_SCAN_LZB_EN
            if ((idx == 2 && d[11:8] == 4'd0) || (idx == 1 && d[11:4] == 8'd0))
                s = 7'b0000000;
`endif
        end
    endfunction

    task automatic cyc(input logic exp_rdy);
        logic [6:0] es;
        logic [2:0] ed;
        @(posedge clk);
        edges++;
        @(negedge clk);
        model(edges, disp_m, en_m, es, ed);
        chk("seg", {1'b0, seg_o}, {1'b0, es});
        chk("dig_n", {5'b0, dig_n_o}, {5'b0, ed});
        chk("ready", {7'b0, bus.ready_o}, {7'b0, exp_rdy});
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", {7'b0, bus.ready_o}, 8'd1);
        chk("rst_dig_n", {5'b0, dig_n_o}, 8'b0000_0111);
        chk("rst_seg", {1'b0, seg_o}, 8'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable_i    = 1'b1;
        en_m        = 1'b1;
        bus.valid_i = 1'b0;
        bus.value_i = 8'd0;
        disp_m      = 12'h000;

        // Reset held
        repeat (3) begin
            @(negedge clk);
            chk_reset_state();
        end
        rst_n = 1'b1;
        edges = 0;

        // Scan order and dead time on zero display
        repeat (26) cyc(1'b1);

        // Convert 255: ready low for 8 cycles, then 2,5,5
        bus.valid_i = 1'b1;
        bus.value_i = 8'd255;
        cyc(1'b0);
        bus.valid_i = 1'b0;
        bus.value_i = 8'd0;
        repeat (7) cyc(1'b0);
        cyc(1'b1);
        disp_m = 12'h255;
        repeat (24) cyc(1'b1);

        // Convert 7: leading digits zero
        bus.valid_i = 1'b1;
        bus.value_i = 8'd7;
        cyc(1'b0);
        bus.valid_i = 1'b0;
        repeat (7) cyc(1'b0);
        cyc(1'b1);
        disp_m = 12'h007;
        repeat (24) cyc(1'b1);

        // Back-to-back 12 then 34 with valid held high
        bus.valid_i = 1'b1;
        bus.value_i = 8'd12;
        cyc(1'b0);
        bus.value_i = 8'd34;
        repeat (7) cyc(1'b0);
        cyc(1'b1);
        disp_m = 12'h012;
        cyc(1'b0);
        bus.valid_i = 1'b0;
        repeat (7) cyc(1'b0);
        cyc(1'b1);
        disp_m = 12'h034;
        repeat (24) cyc(1'b1);

        // Reset 3 cycles into converting 200
        bus.valid_i = 1'b1;
        bus.value_i = 8'd200;
        cyc(1'b0);
        bus.valid_i = 1'b0;
        repeat (3) cyc(1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        repeat (2) begin
            @(negedge clk);
            chk_reset_state();
        end
        rst_n  = 1'b1;
        edges  = 0;
        disp_m = 12'h000;
        repeat (26) cyc(1'b1);

        // Display disabled: dark, scanner keeps running
        bus.valid_i = 1'b1;
        bus.value_i = 8'd94;
        cyc(1'b0);
        bus.valid_i = 1'b0;
        repeat (7) cyc(1'b0);
        cyc(1'b1);
        disp_m   = 12'h094;
        enable_i = 1'b0;
        en_m     = 1'b0;
        repeat (21) cyc(1'b1);
        enable_i = 1'b1;
        en_m     = 1'b1;
        repeat (24) cyc(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d observed=timeout expected=finish", edges);
        $fatal(1, "watchdog expired");
    end

endmodule
